// File: rtl/rvx_irq_gateway.sv
// Fast-interrupt gateway: synchronizes raw peripheral lines, detects level or rising-edge events
// and holds a request per source until the core acknowledges it with irq_fast_response.
module rvx_irq_gateway #(
  parameter int unsigned NUM_SOURCES = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] EDGE_MODE   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] irq_source,
  input  logic [15:0] irq_enable,
  input  logic [15:0] irq_fast_response,
  input  logic [15:0] irq_overrun_clear,
  output logic [15:0] irq_fast_request,
  output logic [15:0] irq_overrun
);

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StAcked
  } state_e;

  for (genvar i = 0; i < 16; i++) begin : g_src
    if (i < NUM_SOURCES) begin : g_active
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   prev_q;
      logic                   overrun_q;
      state_e                 state_q;
      logic                   s;
      logic                   evt;
      logic                   ovf_set;

      assign s   = sync_q[SYNC_STAGES-1];
      assign evt = EDGE_MODE[i] ? (s & ~prev_q) : s;
      // A new edge that lands together with the response re-arms the request instead of overrunning.
      assign ovf_set = EDGE_MODE[i] & evt & (state_q == StPending) & ~irq_fast_response[i];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          sync_q    <= '0;
          prev_q    <= 1'b0;
          overrun_q <= 1'b0;
          state_q   <= StIdle;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], irq_source[i]};
          prev_q <= s;

          if (ovf_set) begin
            overrun_q <= 1'b1;
          end else if (irq_overrun_clear[i]) begin
            overrun_q <= 1'b0;
          end

          case (state_q)
            StIdle: begin
              if (evt) state_q <= StPending;
            end
            StPending: begin
              if (irq_fast_response[i]) begin
                if (EDGE_MODE[i]) begin
                  state_q <= evt ? StPending : StIdle;
                end else begin
                  state_q <= StAcked;
                end
              end
            end
            StAcked: begin
              // Level sources must drop their line before they can request again.
              if (!s) state_q <= StIdle;
            end
            default: state_q <= StIdle;
          endcase
        end
      end

      assign irq_fast_request[i] = (state_q == StPending) & irq_enable[i];
      assign irq_overrun[i]      = overrun_q;
    end else begin : g_tied
      logic unused_in;
      assign unused_in = ^{irq_source[i], irq_enable[i], irq_fast_response[i],
                           irq_overrun_clear[i]};
      assign irq_fast_request[i] = 1'b0;
      assign irq_overrun[i]      = 1'b0;
    end
  end

endmodule

// File: tb/tb_rvx_irq_gateway.sv
// Directed bench for rvx_irq_gateway: stimulus queues timed expectations, a negedge monitor
// pops and compares them against a full 16-source instance and a 4-source instance.
module tb_rvx_irq_gateway;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] irq_source;
  logic [15:0] irq_enable;
  logic [15:0] irq_fast_response;
  logic [15:0] irq_overrun_clear;
  logic [15:0] req_a, ovf_a, req_b, ovf_b;

  always #5 clock = ~clock;

  rvx_irq_gateway #(
    .NUM_SOURCES(16),
    .SYNC_STAGES(2),
    .EDGE_MODE  (16'h00A0)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .irq_source       (irq_source),
    .irq_enable       (irq_enable),
    .irq_fast_response(irq_fast_response),
    .irq_overrun_clear(irq_overrun_clear),
    .irq_fast_request (req_a),
    .irq_overrun      (ovf_a)
  );

  rvx_irq_gateway #(
    .NUM_SOURCES(4),
    .SYNC_STAGES(2),
    .EDGE_MODE  (16'h0000)
  ) dut4 (
    .clock            (clock),
    .reset_n          (reset_n),
    .irq_source       (irq_source),
    .irq_enable       (irq_enable),
    .irq_fast_response(irq_fast_response),
    .irq_overrun_clear(irq_overrun_clear),
    .irq_fast_request (req_b),
    .irq_overrun      (ovf_b)
  );

  typedef struct {
    int          cyc;
    int          sel;  // 0 req_a, 1 ovf_a, 2 req_b, 3 ovf_b
    logic [15:0] mask;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] pick(int sel);
    case (sel)
      0:       return req_a;
      1:       return ovf_a;
      2:       return req_b;
      default: return ovf_b;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, plus the tied-off upper sources.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t        e;
      logic [15:0] act;
      e   = q.pop_front();
      act = pick(e.sel) & e.mask;
      n_checks++;
      if (e.cyc != cyc || act != e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h (due cycle %0d, now %0d)",
                 e.name, act, e.val, e.cyc, cyc);
      end
    end
    n_checks++;
    if ((req_b[15:4] | ovf_b[15:4]) != 12'h000) begin
      n_fail++;
      $display("FAIL tied_upper: got req %h ovf %h, want 000 000", req_b[15:4], ovf_b[15:4]);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(int d, int sel, logic [15:0] mask, logic [15:0] val, string name);
    exp_t e;
    e.cyc  = cyc + d;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin
    reset_n           = 1'b0;
    irq_source        = 16'hFFFF;
    irq_enable        = 16'hFFFF;
    irq_fast_response = 16'h0000;
    irq_overrun_clear = 16'h0000;

    // Reset with all lines high
    tick(1);
    push(1, 0, 16'hFFFF, 16'h0000, "rst_req");
    push(1, 1, 16'hFFFF, 16'h0000, "rst_ovf");
    push(2, 2, 16'hFFFF, 16'h0000, "rst_req4");
    tick(2);
    reset_n = 1'b1;
    push(1, 0, 16'hFFFF, 16'h0000, "post_rst_req");
    push(1, 1, 16'hFFFF, 16'h0000, "post_rst_ovf");
    tick(1);
    reset_n    = 1'b0;
    irq_source = 16'h0000;
    tick(2);
    reset_n = 1'b1;
    tick(3);

    // Level src 3: latency, response, hold-off while line high
    push(2, 0, 16'h0008, 16'h0000, "lvl3_early");
    push(3, 0, 16'h0008, 16'h0008, "lvl3_req");
    irq_source[3] = 1'b1;
    tick(3);
    push(1, 0, 16'h0008, 16'h0000, "lvl3_ack");
    push(2, 0, 16'h0008, 16'h0000, "lvl3_hold1");
    push(4, 0, 16'h0008, 16'h0000, "lvl3_hold2");
    irq_fast_response[3] = 1'b1;
    tick(1);
    irq_fast_response[3] = 1'b0;
    tick(3);
    // Re-arm: drop line, then raise again
    push(3, 0, 16'h0008, 16'h0000, "lvl3_low");
    irq_source[3] = 1'b0;
    tick(3);
    push(2, 0, 16'h0008, 16'h0000, "lvl3_rearm_early");
    push(3, 0, 16'h0008, 16'h0008, "lvl3_rearm");
    irq_source[3] = 1'b1;
    tick(3);
    irq_fast_response[3] = 1'b1;
    tick(1);
    irq_fast_response[3] = 1'b0;
    irq_source[3]        = 1'b0;
    tick(4);

    // Edge src 5: two pulses before any response
    push(3, 0, 16'h0020, 16'h0020, "edge5_req");
    push(6, 1, 16'h0020, 16'h0000, "edge5_ovf_before");
    push(7, 0, 16'h0020, 16'h0020, "edge5_single_req");
    push(7, 1, 16'h0020, 16'h0020, "edge5_ovf");
    irq_source[5] = 1'b1;
    tick(2);
    irq_source[5] = 1'b0;
    tick(2);
    irq_source[5] = 1'b1;
    tick(2);
    irq_source[5] = 1'b0;
    tick(1);
    push(1, 1, 16'h0020, 16'h0000, "edge5_clear");
    irq_overrun_clear[5] = 1'b1;
    tick(1);
    irq_overrun_clear[5] = 1'b0;
    push(1, 0, 16'h0020, 16'h0000, "edge5_resp");
    irq_fast_response[5] = 1'b1;
    tick(1);
    irq_fast_response[5] = 1'b0;
    tick(2);

    // Edge src 7: second edge coincides with the response
    push(3, 0, 16'h0080, 16'h0080, "edge7_req");
    push(7, 0, 16'h0080, 16'h0080, "edge7_kept");
    push(7, 1, 16'h0080, 16'h0000, "edge7_no_ovf");
    push(8, 0, 16'h0080, 16'h0080, "edge7_still");
    push(9, 0, 16'h0080, 16'h0000, "edge7_done");
    irq_source[7] = 1'b1;
    tick(2);
    irq_source[7] = 1'b0;
    tick(2);
    irq_source[7] = 1'b1;
    tick(2);
    irq_source[7]        = 1'b0;
    irq_fast_response[7] = 1'b1;
    tick(1);
    irq_fast_response[7] = 1'b0;
    tick(1);
    irq_fast_response[7] = 1'b1;
    tick(1);
    irq_fast_response[7] = 1'b0;
    tick(2);

    // Overrun set vs clear in the same cycle on src 5
    push(6, 1, 16'h0020, 16'h0000, "prio_before");
    push(7, 1, 16'h0020, 16'h0020, "prio_set_wins");
    push(8, 1, 16'h0020, 16'h0020, "prio_sticky");
    push(9, 1, 16'h0020, 16'h0000, "prio_cleared");
    push(10, 0, 16'h0020, 16'h0000, "prio_resp");
    irq_source[5] = 1'b1;
    tick(2);
    irq_source[5] = 1'b0;
    tick(2);
    irq_source[5] = 1'b1;
    tick(2);
    irq_source[5]        = 1'b0;
    irq_overrun_clear[5] = 1'b1;
    tick(1);
    irq_overrun_clear[5] = 1'b0;
    tick(1);
    irq_overrun_clear[5] = 1'b1;
    tick(1);
    irq_overrun_clear[5] = 1'b0;
    irq_fast_response[5] = 1'b1;
    tick(1);
    irq_fast_response[5] = 1'b0;
    tick(2);

    // Enable gating on level src 2
    push(3, 0, 16'h0004, 16'h0000, "gate2_hidden");
    push(4, 0, 16'h0004, 16'h0000, "gate2_hidden2");
    push(5, 0, 16'h0004, 16'h0004, "gate2_shown");
    push(6, 0, 16'h0004, 16'h0000, "gate2_ack");
    irq_enable[2] = 1'b0;
    irq_source[2] = 1'b1;
    tick(5);
    irq_enable[2]        = 1'b1;
    irq_fast_response[2] = 1'b1;
    irq_source[2]        = 1'b0;
    tick(1);
    irq_fast_response[2] = 1'b0;
    tick(4);

    // Mid-operation reset with requests pending; src 9 ignored by the 4-source instance
    push(3, 0, 16'hFFFF, 16'h0203, "mid_pending");
    push(3, 2, 16'hFFFF, 16'h0003, "mid_pending4");
    push(4, 0, 16'hFFFF, 16'h0000, "mid_rst_req");
    push(4, 1, 16'hFFFF, 16'h0000, "mid_rst_ovf");
    push(4, 2, 16'hFFFF, 16'h0000, "mid_rst_req4");
    irq_source = 16'h0203;
    tick(4);
    #2;
    reset_n = 1'b0;
    tick(2);
    irq_source = 16'h0000;
    reset_n    = 1'b1;
    tick(2);

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clock);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: got never checked, want checked at cycle %0d", e.name, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
